axi_burst_sequencer: RTL

//  Upstream command front-end for axi_burst_master. Accepts one multi-beat transfer (address + total beat count), splits it

---
 rtl/axi_seq_pkg.sv | 21 ++
 rtl/axi_burst_len_calc.sv | 24 ++
 rtl/axi_burst_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/axi_seq_pkg.sv
// Shared constants for the AXI burst sequencer: FSM encoding, 4 KB page size,
// AXI response codes and beat-size helper.
package axi_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CALC  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int AXI_4K = 4096;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int bytes_log2(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst sizing: min(remaining, MAX_BURST, beats left in the 4 KB page).
module axi_burst_len_calc
    import axi_seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MAX_BURST  = 256,
    parameter int LOG2_BYTES = 3
) (
    input  logic [CNT_W-1:0] remaining,
    input  logic [11:0]      addr_lo,
    output logic [8:0]       len
);

    logic [12:0] bound;
    logic [12:0] lim;

    always_comb begin
        // Start address is beat-aligned, so the page remainder is a whole number of beats.
        bound = (13'(AXI_4K) - {1'b0, addr_lo}) >> LOG2_BYTES;
        lim   = (bound < 13'(MAX_BURST)) ? bound : 13'(MAX_BURST);
        len   = (32'(remaining) < 32'(lim)) ? 9'(remaining) : lim[8:0];
    end

endmodule

// File: rtl/axi_burst_sequencer.sv
// Splits one multi-beat command into 4 KB-safe INCR bursts for axi_burst_master
// and bridges the client write/read streams to the master's user interface.
module axi_burst_sequencer
    import axi_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_w_r,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [CNT_W-1:0]    cmd_beats,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                m_rvalid,
    output logic                done,
    output logic                err,
    output logic                mst_start,
    output logic                mst_w_r,
    output logic [7:0]          mst_burst_len,
    output logic [ADDR_W-1:0]   mst_addr,
    output logic [DATA_W/8-1:0] mst_data_strb,
    output logic [DATA_W-1:0]   mst_data_in,
    input  logic                mst_free,
    input  logic                mst_stall_w,
    input  logic [1:0]          mst_status,
    input  logic [DATA_W-1:0]   mst_dout,
    input  logic                mst_dout_valid
);

    localparam int LOG2B = bytes_log2(DATA_W);

    logic [2:0]        state, state_nxt;
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [8:0]        len_q, beat_cnt, calc_len;
    logic              accept, wait_wr, wait_rd, burst_end;

    axi_burst_len_calc #(
        .CNT_W      (CNT_W),
        .MAX_BURST  (MAX_BURST),
        .LOG2_BYTES (LOG2B)
    ) u_len_calc (
        .remaining (remaining),
        .addr_lo   (addr[11:0]),
        .len       (calc_len)
    );

    assign accept  = cmd_valid & cmd_ready;
    assign wait_wr = (state == ST_WAIT) && !w_r;
    assign wait_rd = (state == ST_WAIT) && w_r;

    assign s_wready      = wait_wr && !mst_stall_w && (beat_cnt < len_q);
    assign mst_data_in   = wait_wr ? s_wdata : '0;
    assign m_rvalid      = wait_rd && mst_dout_valid;
    assign m_rdata       = wait_rd ? mst_dout : '0;
    assign mst_start     = (state == ST_ISSUE) && mst_free;
    assign mst_w_r       = w_r;
    assign mst_addr      = addr;
    assign mst_data_strb = (!w_r && (state == ST_ISSUE || state == ST_WAIT)) ? '1 : '0;

    // A write burst closes on the write response; a read burst on its last data beat.
    assign burst_end = wait_wr ? mst_dout_valid
                               : (wait_rd && mst_dout_valid && (beat_cnt == len_q - 9'd1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (cmd_beats == '0) ? ST_DONE : ST_CALC;
            ST_CALC:  state_nxt = ST_ISSUE;
            ST_ISSUE: if (mst_free) state_nxt = ST_WAIT;
            ST_WAIT:  if (burst_end) state_nxt = (remaining == CNT_W'(len_q)) ? ST_DONE : ST_CALC;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            w_r           <= 1'b0;
            addr          <= '0;
            remaining     <= '0;
            len_q         <= '0;
            beat_cnt      <= '0;
            mst_burst_len <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            done      <= (state == ST_DONE);
            case (state)
                ST_IDLE: if (accept) begin
                    w_r       <= cmd_w_r;
                    addr      <= cmd_addr;
                    remaining <= cmd_beats;
                    err       <= 1'b0;
                end
                ST_CALC: begin
                    len_q         <= calc_len;
                    mst_burst_len <= 8'(calc_len - 9'd1);
                    beat_cnt      <= '0;
                end
                ST_WAIT: begin
                    if ((s_wvalid && s_wready) || (wait_rd && mst_dout_valid))
                        beat_cnt <= beat_cnt + 9'd1;
                    if (burst_end) begin
                        err       <= err | (mst_status != RESP_OKAY);
                        addr      <= addr + (ADDR_W'(len_q) << LOG2B);
                        remaining <= remaining - CNT_W'(len_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
